toggle_monitor: RTL and testbench
=================================

TOGGLE_MONITOR -- requirements
Module: toggle_monitor

Interface
REQ-001 The block SHALL provide parameter CNT_W, default 8, width of the period counter and period output.
REQ-002 The block SHALL provide parameter TIMEOUT, default 200, idle cycles after a rising edge before a stall is flagged; legal range 2..2^CNT_W-2.
REQ-003 The block SHALL provide port clk  input  1  the single clock; all state on rising edge.
REQ-004 The block SHALL provide port reset_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL provide port sig_in  input  1  monitored 1-bit state stream from the upstream state machine output.
REQ-006 The block SHALL provide port enable  input  1  monitor enable.
REQ-007 The block SHALL provide port period  output  CNT_W  measured rising-edge-to-rising-edge distance in clk cycles.
REQ-008 The block SHALL provide port period_valid  output  1  period holds an unconsumed result.
REQ-009 The block SHALL provide port period_ready  input  1  consumer accepts period this cycle.
REQ-010 The block SHALL provide port overflow  output  1  sticky flag, a result was dropped.
REQ-011 The block SHALL provide port stall  output  1  no rising edge within TIMEOUT cycles.
REQ-012 The block SHALL provide port edge_count  output  16  rising edges seen while enabled.

Function
REQ-013 The block SHALL register the sampled input into sig_d each cycle; rise = sampled sig_in high and sig_d low.
REQ-014 The FSM SHALL have states IDLE, ARMED, MEASURE, STALL.
REQ-015 IDLE -> ARMED when enable=1; ARMED -> MEASURE on rise, loading cnt=1, no result produced.
REQ-016 In MEASURE, on rise the block SHALL present cnt as a new result and reload cnt=1; otherwise cnt increments by 1.
REQ-017 In MEASURE, when cnt==TIMEOUT and no rise, the FSM SHALL go to STALL and set stall=1 next cycle.
REQ-018 STALL -> MEASURE on rise, loading cnt=1, clearing stall, producing no result.
REQ-019 enable=0 in any state SHALL force IDLE next cycle, clear cnt, stall and overflow; period/period_valid are retained until handshake.
REQ-020 A result SHALL appear on period with period_valid=1 the cycle after the rise cycle (latency 1 without sync).
REQ-021 period_valid SHALL stay high with period stable until a cycle with period_ready=1.
REQ-022 New result with period_valid=1 and period_ready=0: new result dropped, old one kept, overflow set.
REQ-023 New result with period_valid=1 and period_ready=1 in same cycle: new result loaded, period_valid stays 1, no overflow.
REQ-024 edge_count SHALL increment on every rise while state is not IDLE, wrapping 0xFFFF -> 0x0000.

Reset
REQ-025 reset_n=0 SHALL immediately force state IDLE, cnt=0, sig_d=0, sync flops=0, period=0, period_valid=0, overflow=0, stall=0, edge_count=0, regardless of clk.
REQ-026 Reset mid-measurement SHALL discard the partial count; the first rise after release produces no result.

Configuration
REQ-027 With macro TOGGLE_MONITOR_SYNC_EN defined, sig_in SHALL pass through a 2-flop synchronizer before sampling, adding exactly 2 cycles to result latency (3 total).
REQ-028 Without TOGGLE_MONITOR_SYNC_EN, sig_in SHALL be sampled directly; measured period values are identical in both builds.

Verification
REQ-029 Reset, enable=1, period_ready=1, sig_in repeating 1,0,0 -> from second rise period=3, period_valid one-cycle pulses every 3 cycles, edge_count +1 per rise.
REQ-030 Same stimulus, period_ready=0 for 10 cycles -> period=3 held, overflow=1 after next rise, period_valid never drops.
REQ-031 Rise then sig_in low 250 cycles (TIMEOUT=200) -> stall=1 from cycle 201 after the rise; next rise clears stall, no result; following rise 4 cycles later -> period=4.
REQ-032 enable dropped mid-MEASURE for 2 cycles then raised -> state IDLE, stall/overflow=0, first rise afterwards gives no result, second gives correct period.
REQ-033 reset_n pulsed low between clk edges during MEASURE with period_valid=1 -> all outputs 0 immediately, before next clk edge.
REQ-034 Build with TOGGLE_MONITOR_SYNC_EN, repeat REQ-029 -> same period=3 values, period_valid exactly 2 cycles later than non-sync build.

Source files
------------

// File: rtl/toggle_monitor.sv
// Rising-edge period monitor with ready/valid result handshake, stall timeout and edge counter.
// Define TOGGLE_MONITOR_SYNC_EN to route sig_in through a 2-flop synchronizer first.
module toggle_monitor #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             overflow,
  output logic             stall,
  output logic [15:0]      edge_count
);

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE, STALL} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             stall_next;
  logic             new_result;
  logic             sig_s;
  logic             sig_d;
  logic             rise;

`ifdef TOGGLE_MONITOR_SYNC_EN
  logic [1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[0], sig_in};
  end

  assign sig_s = sync_q[1];
`else
  assign sig_s = sig_in;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sig_d <= 1'b0;
    else          sig_d <= sig_s;
  end

  assign rise = sig_s & ~sig_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      stall <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      stall <= stall_next;
    end
  end

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall_next = stall;
    new_result = 1'b0;
    if (!enable) begin
      state_next = IDLE;
      cnt_next   = '0;
      stall_next = 1'b0;
    end else begin
      unique case (state)
        IDLE: state_next = ARMED;
        ARMED: begin
          if (rise) begin
            state_next = MEASURE;
            cnt_next   = CNT_ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            new_result = 1'b1;
            cnt_next   = CNT_ONE;
          end else if (cnt == TIMEOUT_C) begin
            state_next = STALL;
            stall_next = 1'b1;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        STALL: begin
          if (rise) begin
            state_next = MEASURE;
            cnt_next   = CNT_ONE;
            stall_next = 1'b0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // A pending result is only replaced when the consumer takes it in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period       <= '0;
      period_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (period_valid && period_ready) period_valid <= 1'b0;
      if (new_result) begin
        if (!period_valid || period_ready) begin
          period       <= cnt;
          period_valid <= 1'b1;
        end
      end
      if (!enable)
        overflow <= 1'b0;
      else if (new_result && period_valid && !period_ready)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      edge_count <= '0;
    else if (rise && enable && (state != IDLE))
      edge_count <= edge_count + 16'd1;
  end

endmodule

// File: tb/tb_toggle_monitor.sv
// Directed bench for toggle_monitor (default build, TIMEOUT=200, CNT_W=8).
module tb_toggle_monitor;

  logic        clk;
  logic        reset_n;
  logic        sig_in;
  logic        enable;
  logic [7:0]  period;
  logic        period_valid;
  logic        period_ready;
  logic        overflow;
  logic        stall;
  logic [15:0] edge_count;

  int n_vec = 0;
  int n_err = 0;

  toggle_monitor #(.CNT_W(8), .TIMEOUT(200)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sig_in       (sig_in),
    .enable       (enable),
    .period       (period),
    .period_valid (period_valid),
    .period_ready (period_ready),
    .overflow     (overflow),
    .stall        (stall),
    .edge_count   (edge_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"}, 32'(period), 0);
    check({tag, "_valid"}, 32'(period_valid), 0);
    check({tag, "_ovf"}, 32'(overflow), 0);
    check({tag, "_stall"}, 32'(stall), 0);
    check({tag, "_edges"}, 32'(edge_count), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; sig_in = 1'b0; period_ready = 1'b1;
    #7;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // 1,0,0 stream with a consumer always ready
    enable = 1'b1; sig_in = 1'b0; tick();
    check("armed_edges", 32'(edge_count), 0);
    for (int p = 0; p < 4; p++) begin
      sig_in = 1'b1; tick();
      check("a_rise_valid", 32'(period_valid), (p > 0) ? 1 : 0);
      if (p > 0) check("a_period", 32'(period), 3);
      check("a_edges", 32'(edge_count), 32'(p + 1));
      sig_in = 1'b0; tick();
      check("a_gap1_valid", 32'(period_valid), 0);
      sig_in = 1'b0; tick();
      check("a_gap2_valid", 32'(period_valid), 0);
    end

    // consumer stalls for 10 cycles: result held, later ones dropped
    period_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      sig_in = (i % 3 == 1); tick();
      check("b_valid", 32'(period_valid), 1);
      check("b_period", 32'(period), 3);
      check("b_ovf", 32'(overflow), (i >= 4) ? 1 : 0);
    end
    check("b_edges", 32'(edge_count), 8);
    period_ready = 1'b1; sig_in = 1'b0; tick();
    check("b_drain_valid", 32'(period_valid), 0);
    check("b_ovf_sticky", 32'(overflow), 1);
    sig_in = 1'b0; tick();

    // enable drop mid-measure with a result pending
    sig_in = 1'b1; period_ready = 1'b0; tick();
    check("c_valid", 32'(period_valid), 1);
    check("c_period", 32'(period), 3);
    check("c_edges", 32'(edge_count), 9);
    enable = 1'b0; sig_in = 1'b0; tick();
    check("c_dis_ovf", 32'(overflow), 0);
    check("c_dis_stall", 32'(stall), 0);
    check("c_dis_valid_kept", 32'(period_valid), 1);
    check("c_dis_period_kept", 32'(period), 3);
    sig_in = 1'b1; tick();
    check("c_dis_edges", 32'(edge_count), 9);
    enable = 1'b1; sig_in = 1'b0; period_ready = 1'b1; tick();
    check("c_accept_valid", 32'(period_valid), 0);
    sig_in = 1'b1; tick();
    check("c_first_rise_valid", 32'(period_valid), 0);
    check("c_first_rise_edges", 32'(edge_count), 10);
    repeat (4) begin sig_in = 1'b0; tick(); end
    sig_in = 1'b1; tick();
    check("c_second_valid", 32'(period_valid), 1);
    check("c_second_period", 32'(period), 5);
    check("c_second_edges", 32'(edge_count), 11);

    // stall after TIMEOUT idle cycles
    for (int k = 1; k <= 250; k++) begin
      sig_in = 1'b0; tick();
      if (k == 1) check("d_valid_drop", 32'(period_valid), 0);
      if (k == 199 || k == 200 || k == 250)
        check($sformatf("d_stall_k%0d", k), 32'(stall), (k >= 200) ? 1 : 0);
    end
    sig_in = 1'b1; tick();
    check("d_stall_clear", 32'(stall), 0);
    check("d_no_result", 32'(period_valid), 0);
    check("d_edges", 32'(edge_count), 12);
    repeat (3) begin sig_in = 1'b0; tick(); end
    sig_in = 1'b1; tick();
    check("d_period", 32'(period), 4);
    check("d_valid", 32'(period_valid), 1);
    check("d_edges2", 32'(edge_count), 13);

    // asynchronous reset between clock edges
    period_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    enable = 1'b1; sig_in = 1'b0; tick();
    sig_in = 1'b1; tick();
    check("e_first_rise_valid", 32'(period_valid), 0);
    check("e_edges", 32'(edge_count), 1);
    sig_in = 1'b0; tick();
    sig_in = 1'b1; tick();
    check("e_period2", 32'(period), 2);
    check("e_valid", 32'(period_valid), 1);
    sig_in = 1'b0; tick();
    sig_in = 1'b0; tick();
    check("e_valid_held", 32'(period_valid), 1);
    period_ready = 1'b1; sig_in = 1'b1; tick();
    check("e_swap_period", 32'(period), 3);
    check("e_swap_valid", 32'(period_valid), 1);
    check("e_swap_ovf", 32'(overflow), 0);
    sig_in = 1'b0; tick();
    check("e_final_valid", 32'(period_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
